imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: searches for an 8-bit immediate plus even right-rotation that
// reproduces a 32-bit constant. This is the ARM data-processing
// shift_operand form.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          encode request, sampled only while idle
//   value[31:0]    constant to encode, captured on the accepted start edge
//   busy           high while the rotation search runs
//   done           one-cycle pulse, result outputs valid
//   valid          1 = an encoding was found
//   shift_operand  [11:8] rotate_imm, [7:0] immed_8
//   inv            1 = the encoding is of ~value (MOV/MVN swap)
//
// Optional feature: define INVERT_EN to add a second search pass over the
// complemented constant. When INVERT_EN is undefined, inv is tied low.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] shift_operand,
  output logic        inv
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] operand_r;
  logic [3:0]  r_r;
  logic        valid_r;
  logic [11:0] shift_operand_r;
  logic [31:0] candidate_s;
  logic        hit_s;
  logic        last_s;
  logic        flip_s;
  logic        give_up_s;
`ifdef INVERT_EN
  logic        phase_r;
  logic        inv_r;
`endif

  // Rotate left by 2*r. This undoes the decoder's rotate right, so a hit
  // exposes immed_8 in the low byte.
  function automatic logic [31:0] rotl2(input logic [31:0] x, input logic [3:0] r);
    logic [63:0] dbl;
    dbl = {x, x} << {r, 1'b0};
    return dbl[63:32];
  endfunction

  assign candidate_s = rotl2(operand_r, r_r);
  assign hit_s       = (candidate_s[31:8] == 24'd0);
  assign last_s      = (r_r == 4'd15);

  // Decide what a miss on the final rotation means: flip to the complement
  // pass (if enabled and not already done) or give up.
  always_comb begin
    flip_s    = 1'b0;
    give_up_s = 1'b0;
    if (last_s && !hit_s) begin
`ifdef INVERT_EN
      flip_s    = !phase_r;
      give_up_s = phase_r;
`else
      give_up_s = 1'b1;
`endif
    end else begin
      flip_s    = 1'b0;
      give_up_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SEARCH;
        else       state_s = IDLE;
      end
      SEARCH: begin
        if (hit_s || give_up_s) state_s = DONE;
        else                    state_s = SEARCH;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Search datapath: operand capture, rotation counter, and result registers.
  // Results change only on the transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_r       <= 32'd0;
      r_r             <= 4'd0;
      valid_r         <= 1'b0;
      shift_operand_r <= 12'd0;
`ifdef INVERT_EN
      phase_r         <= 1'b0;
      inv_r           <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            operand_r <= value;
            r_r       <= 4'd0;
`ifdef INVERT_EN
            phase_r   <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (hit_s) begin
            valid_r         <= 1'b1;
            shift_operand_r <= {r_r, candidate_s[7:0]};
`ifdef INVERT_EN
            inv_r           <= phase_r;
`endif
          end else if (give_up_s) begin
            valid_r         <= 1'b0;
            shift_operand_r <= 12'd0;
`ifdef INVERT_EN
            inv_r           <= 1'b0;
`endif
          end else if (flip_s) begin
            operand_r <= ~operand_r;
            r_r       <= 4'd0;
`ifdef INVERT_EN
            phase_r   <= 1'b1;
`endif
          end else begin
            r_r <= r_r + 4'd1;
          end
        end
        DONE: begin
          r_r <= 4'd0;
        end
        default: begin
          r_r <= 4'd0;
        end
      endcase
    end
  end

  assign busy          = (state_r == SEARCH);
  assign done          = (state_r == DONE);
  assign valid         = valid_r;
  assign shift_operand = shift_operand_r;
`ifdef INVERT_EN
  assign inv           = inv_r;
`else
  assign inv           = 1'b0;
`endif

endmodule
